// File: rtl/tdm_mux_4_to_1.sv
// rtl/tdm_mux_4_to_1.sv - round-robin 4-to-1 TDM transmitter; optional TDM_CHANNEL_MASK_EN adds i_Mask
module tdm_mux_4_to_1 #(
    parameter int SLOT_CYCLES = 1000
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Enable,
    input  logic       i_Data0,
    input  logic       i_Data1,
    input  logic       i_Data2,
    input  logic       i_Data3,
`ifdef TDM_CHANNEL_MASK_EN
    input  logic [3:0] i_Mask,
`endif
    output logic       o_Data,
    output logic       o_Sel0,
    output logic       o_Sel1,
    output logic       o_Frame_Start,
    output logic       o_Active
);

    localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(SLOT_CYCLES - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_next;
    logic [CW-1:0] count, count_next;
    logic [1:0]    slot, slot_next;
    logic          data_q, data_next;
    logic          frame_q, frame_next;
    logic [3:0]    data_vec;

    assign data_vec = {i_Data3, i_Data2, i_Data1, i_Data0};

`ifdef TDM_CHANNEL_MASK_EN
    // Returns {found, index} of the first enabled channel at or after start.
    function automatic logic [2:0] first_enabled(input logic [3:0] mask, input logic [1:0] start);
        logic [2:0] r;
        logic [1:0] idx;
        r = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (mask[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

    logic [2:0] pick_entry, pick_next;
    assign pick_entry = first_enabled(i_Mask, 2'd0);
    assign pick_next  = first_enabled(i_Mask, slot + 2'd1);
`endif

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state   <= IDLE;
            count   <= '0;
            slot    <= 2'd0;
            data_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            state   <= state_next;
            count   <= count_next;
            slot    <= slot_next;
            data_q  <= data_next;
            frame_q <= frame_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        slot_next  = slot;
        data_next  = data_q;
        frame_next = 1'b0;
        case (state)
            IDLE: begin
                count_next = '0;
                slot_next  = 2'd0;
                data_next  = 1'b0;
                if (i_Enable) begin
                    state_next = RUN;
`ifdef TDM_CHANNEL_MASK_EN
                    if (pick_entry[2]) begin
                        slot_next  = pick_entry[1:0];
                        data_next  = data_vec[pick_entry[1:0]];
                        frame_next = 1'b1;
                    end
`else
                    data_next  = i_Data0;
                    frame_next = 1'b1;
`endif
                end
            end
            RUN: begin
                if (!i_Enable) begin
                    state_next = IDLE;
                    count_next = '0;
                    slot_next  = 2'd0;
                    data_next  = 1'b0;
                end else if (count == LAST) begin
                    count_next = '0;
`ifdef TDM_CHANNEL_MASK_EN
                    if (pick_next[2]) begin
                        slot_next  = pick_next[1:0];
                        data_next  = data_vec[pick_next[1:0]];
                        frame_next = (pick_next[1:0] <= slot);
                    end else begin
                        data_next = 1'b0;
                    end
`else
                    slot_next  = slot + 2'd1;
                    data_next  = data_vec[slot_next];
                    frame_next = (slot_next == 2'd0);
`endif
                end else begin
                    count_next = count + CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Select and data come from registers loaded on the same edge, so they stay aligned.
    assign o_Data        = data_q;
    assign o_Sel0        = slot[0];
    assign o_Sel1        = slot[1];
    assign o_Frame_Start = frame_q;
    assign o_Active      = (state == RUN);

endmodule
